// File: rtl/lcd_char_writer.sv
// lcd_char_writer
// Accepts ASCII bytes over a valid/ready handshake and writes them to a 2x16
// HD44780-compatible LCD over an 8-bit parallel bus. Handles the power-up wait,
// the fixed init command sequence, E-strobe timing, and automatic line-2 /
// wrap cursor commands.
//
// Build option: define LCD_CLEAR_ON_WRAP_EN to clear the display (0x01) when
// the cursor wraps past position 31. Without it the cursor is sent home to
// line 1 (0x80), and the old characters are overwritten.

module lcd_char_writer #(
  parameter int E_PULSE_CYC   = 12,
  parameter int CMD_WAIT_CYC  = 2500,
  parameter int CLR_WAIT_CYC  = 82000,
  parameter int INIT_WAIT_CYC = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [4:0] char_cnt
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One down-counter serves every wait, so it is sized for the longest one.
  localparam int MAX_CYC = max2(max2(E_PULSE_CYC, CMD_WAIT_CYC),
                                max2(CLR_WAIT_CYC, INIT_WAIT_CYC));
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  // Counters run from LOAD down to 0 inclusive, so LOAD = cycles - 1.
  localparam cnt_t E_LOAD    = cnt_t'(E_PULSE_CYC - 1);
  localparam cnt_t CMD_LOAD  = cnt_t'(CMD_WAIT_CYC - 1);
  localparam cnt_t CLR_LOAD  = cnt_t'(CLR_WAIT_CYC - 1);
  localparam cnt_t INIT_LOAD = cnt_t'(INIT_WAIT_CYC - 1);

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_CLEAR    = 8'h01;  // clear display (slow command)
  localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_LINE2    = 8'hC0;  // DDRAM address 0x40
  localparam logic [7:0] CMD_LINE1    = 8'h80;  // DDRAM address 0x00

`ifdef LCD_CLEAR_ON_WRAP_EN
  localparam logic [7:0] WRAP_CMD = CMD_CLEAR;
`else
  localparam logic [7:0] WRAP_CMD = CMD_LINE1;
`endif

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    IDLE,
    SETUP,
    E_HIGH,
    E_WAIT
  } state_t;

  // Fixed power-up command sequence, indexed 0..3.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = CMD_FUNC_SET;
      2'd1:    cmd = CMD_DISP_ON;
      2'd2:    cmd = CMD_CLEAR;
      default: cmd = CMD_ENTRY;
    endcase
    return cmd;
  endfunction

  state_t     state,     state_nxt;
  cnt_t       cnt,       cnt_nxt;
  logic [7:0] data_q,    data_nxt;
  logic       rs_q,      rs_nxt;
  logic       e_q,       e_nxt;
  logic [4:0] char_q,    char_nxt;
  logic [1:0] init_idx,  init_idx_nxt;
  logic       init_busy, init_busy_nxt;

  // Internal line/wrap commands are chained straight from E_WAIT into SETUP,
  // so a pending command never coexists with IDLE; IDLE alone means ready.
  assign in_ready = (state == IDLE) && !rst;

  assign lcd_data = data_q;
  assign lcd_rs   = rs_q;
  assign lcd_e    = e_q;
  assign lcd_rw   = 1'b0;
  assign char_cnt = char_q;

  // Next-state, counter and bus-register logic.
  always_comb begin
    // NOTE: every variable gets a default here first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_nxt     = state;
    cnt_nxt       = cnt;
    data_nxt      = data_q;
    rs_nxt        = rs_q;
    char_nxt      = char_q;
    init_idx_nxt  = init_idx;
    init_busy_nxt = init_busy;

    case (state)
      PWR_WAIT: begin
        if (cnt == '0) state_nxt = INIT;
        else           cnt_nxt   = cnt - 1'b1;
      end

      INIT: begin
        data_nxt      = init_cmd(2'd0);
        rs_nxt        = 1'b0;
        init_idx_nxt  = 2'd0;
        init_busy_nxt = 1'b1;
        state_nxt     = SETUP;
      end

      IDLE: begin
        // in_data is captured only on the handshake cycle.
        if (in_valid && in_ready) begin
          data_nxt  = in_data;
          rs_nxt    = 1'b1;
          state_nxt = SETUP;
        end
      end

      SETUP: begin
        cnt_nxt   = E_LOAD;
        state_nxt = E_HIGH;
      end

      E_HIGH: begin
        if (cnt == '0) begin
          // Clear is the only slow command; data byte 0x01 is a normal write.
          cnt_nxt   = (!rs_q && data_q == CMD_CLEAR) ? CLR_LOAD : CMD_LOAD;
          state_nxt = E_WAIT;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      E_WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (init_busy) begin
          if (init_idx == 2'd3) begin
            init_busy_nxt = 1'b0;
            state_nxt     = IDLE;
          end else begin
            init_idx_nxt = init_idx + 2'd1;
            data_nxt     = init_cmd(init_idx + 2'd1);
            rs_nxt       = 1'b0;
            state_nxt    = SETUP;
          end
        end else if (rs_q) begin
          // A character just landed; advance the cursor and fix up the
          // DDRAM address where the display's address map is not contiguous.
          char_nxt = char_q + 5'd1;
          if (char_q == 5'd15) begin
            data_nxt  = CMD_LINE2;
            rs_nxt    = 1'b0;
            state_nxt = SETUP;
          end else if (char_q == 5'd31) begin
            data_nxt  = WRAP_CMD;
            rs_nxt    = 1'b0;
            state_nxt = SETUP;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = PWR_WAIT;
    endcase

    // E is registered so the pin is glitch-free and follows E_HIGH exactly.
    e_nxt = (state_nxt == E_HIGH);
  end

  // State and bus registers; reset restarts the whole power-up sequence.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state     <= PWR_WAIT;
      cnt       <= INIT_LOAD;
      data_q    <= 8'h00;
      rs_q      <= 1'b0;
      e_q       <= 1'b0;
      char_q    <= 5'd0;
      init_idx  <= 2'd0;
      init_busy <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      data_q    <= data_nxt;
      rs_q      <= rs_nxt;
      e_q       <= e_nxt;
      char_q    <= char_nxt;
      init_idx  <= init_idx_nxt;
      init_busy <= init_busy_nxt;
    end
  end

endmodule
